// File: rtl/cpu_csr_unit.sv
// cpu_csr_unit: supervisor CSR file, cycle/time/instret/hpm counters,
// trap entry/return sequencing and interrupt request generation.
// Optional feature macro: CPU_CSR_VECTORED_EN (enables vectored stvec mode
// for interrupts). The default build without the macro has direct mode only.
module cpu_csr_unit #(
    parameter int unsigned NUM_HPM   = 4,
    parameter int unsigned COUNTER_W = 64,
    parameter int unsigned TIME_DIV  = 1,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [11:0]                              addr,
    input  logic [31:0]                              data_in,
    input  logic [1:0]                               op,
    input  logic                                     wr,
    output logic [31:0]                              data_out,
    output logic                                     illegal,
    input  logic                                     inst_tick,
    input  logic                                     timer_tick,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    input  logic [1:0]                               irq_in,
    input  logic                                     trap,
    input  logic [31:0]                              trap_cause,
    input  logic [31:0]                              trap_pc,
    input  logic [31:0]                              trap_value,
    input  logic                                     trap_ret,
    output logic [31:0]                              handler_addr,
    output logic [31:0]                              return_addr,
    output logic                                     irq_req
);

    localparam int HPM_W = (NUM_HPM > 0) ? int'(NUM_HPM) : 1;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_NONE  = 2'b11
    } csr_op_e;

    // S-mode register addresses
    localparam logic [11:0] ADDR_SSTATUS  = 12'h100;
    localparam logic [11:0] ADDR_SIE      = 12'h104;
    localparam logic [11:0] ADDR_STVEC    = 12'h105;
    localparam logic [11:0] ADDR_SSCRATCH = 12'h140;
    localparam logic [11:0] ADDR_SEPC     = 12'h141;
    localparam logic [11:0] ADDR_SCAUSE   = 12'h142;
    localparam logic [11:0] ADDR_STVAL    = 12'h143;
    localparam logic [11:0] ADDR_SIP      = 12'h144;
    localparam logic [11:0] ADDR_SCNTINH  = 12'h5C0;

    // Writable-bit masks
    localparam logic [31:0] SIE_MASK     = 32'h0000_0222;
    localparam logic [31:0] HPM_INH_BITS = ((32'h1 << NUM_HPM) - 32'h1) << 3;
    localparam logic [31:0] INHIBIT_MASK = 32'h0000_0005 | HPM_INH_BITS;

    localparam logic [15:0]          PRESC_LAST = 16'(TIME_DIV - 1);
    localparam logic [COUNTER_W-1:0] CNT_ONE    = COUNTER_W'(1);

    // Architectural state
    logic [COUNTER_W-1:0] cycle_q;
    logic [COUNTER_W-1:0] time_q;
    logic [COUNTER_W-1:0] instret_q;
    logic [COUNTER_W-1:0] hpm_q [HPM_W];
    logic [15:0]          presc_q;

    logic        st_sie_q;
    logic        st_spie_q;
    logic        st_spp_q;
    logic [31:0] sie_q;
    logic [31:0] stvec_q;
    logic [31:0] sscratch_q;
    logic [31:0] sepc_q;
    logic [31:0] scause_q;
    logic [31:0] stval_q;
    logic        ssip_q;
    logic [31:0] inhibit_q;

    // Previous input levels for rising-edge detection
    logic             inst_prev_q;
    logic             timer_prev_q;
    logic [HPM_W-1:0] hpm_prev_q;

    // Combinational access signals
    csr_op_e     op_e;
    logic [31:0] sstatus_rd;
    logic [31:0] sip_rd;
    logic [63:0] cnt_sel;
    logic [31:0] rdata;
    logic        implemented;
    logic        csr_wr;
    logic        csr_we;
    logic [31:0] wdata;

    assign op_e = csr_op_e'(op);

    // Packed views of sstatus and sip as software sees them
    assign sstatus_rd = {23'd0, st_spp_q, 2'd0, st_spie_q, 3'd0, st_sie_q, 1'b0};
    assign sip_rd     = {22'd0, irq_in[1], 3'd0, irq_in[0], 3'd0, ssip_q, 1'b0};

    // Legalise a value written to stvec: only direct (and optionally vectored) modes stick
    function automatic logic [31:0] stvec_legal(input logic [31:0] v);
`ifdef CPU_CSR_VECTORED_EN
        return {v[31:2], (v[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
        return {v[31:2], 2'b00};
`endif
    endfunction

    // Select the counter addressed by addr[4:0], zero-extended to 64 bits
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_sel = 64'd0;
        if (addr[4:0] == 5'd0) begin
            cnt_sel = 64'(cycle_q);
        end else if (addr[4:0] == 5'd1) begin
            cnt_sel = 64'(time_q);
        end else if (addr[4:0] == 5'd2) begin
            cnt_sel = 64'(instret_q);
        end
        for (int i = 0; i < HPM_W; i++) begin
            if (i < int'(NUM_HPM) && addr[4:0] == 5'(i + 3)) begin
                cnt_sel = 64'(hpm_q[i]);
            end
        end
    end

    // Read mux and address decode; reads always show the pre-update value
    always_comb begin
        rdata       = 32'd0;
        implemented = 1'b1;
        if (addr[11:8] == 4'hC && addr[6:5] == 2'b00) begin
            // C00..C1F low halves, C80..C9F high halves
            rdata = addr[7] ? cnt_sel[63:32] : cnt_sel[31:0];
        end else begin
            case (addr)
                ADDR_SSTATUS:  rdata = sstatus_rd;
                ADDR_SIE:      rdata = sie_q;
                ADDR_STVEC:    rdata = stvec_q;
                ADDR_SSCRATCH: rdata = sscratch_q;
                ADDR_SEPC:     rdata = sepc_q;
                ADDR_SCAUSE:   rdata = scause_q;
                ADDR_STVAL:    rdata = stval_q;
                ADDR_SIP:      rdata = sip_rd;
                ADDR_SCNTINH:  rdata = inhibit_q;
                default:       implemented = 1'b0;
            endcase
        end
    end

    // Operand combine and trap check for the current access
    always_comb begin
        csr_wr  = wr && (op_e != OP_NONE);
        illegal = !implemented || (csr_wr && addr[11:10] == 2'b11);
        csr_we  = csr_wr && !illegal;
        case (op_e)
            OP_WRITE: wdata = data_in;
            OP_SET:   wdata = rdata | data_in;
            OP_CLEAR: wdata = rdata & ~data_in;
            default:  wdata = rdata;
        endcase
    end

    assign data_out    = rdata;
    assign return_addr = sepc_q;

    // Trap target: base address, or base + 4*cause for vectored interrupts
    always_comb begin
        handler_addr = {stvec_q[31:2], 2'b00};
`ifdef CPU_CSR_VECTORED_EN
        if (stvec_q[1:0] == 2'b01 && scause_q[31]) begin
            handler_addr = {stvec_q[31:2], 2'b00} + {25'd0, scause_q[4:0], 2'b00};
        end
`endif
    end

    // S-mode registers: CSR op, then trap return, then trap entry (later assignment wins)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_sie_q   <= 1'b0;
            st_spie_q  <= 1'b0;
            st_spp_q   <= 1'b0;
            sie_q      <= 32'd0;
            stvec_q    <= RESET_VEC;
            sscratch_q <= 32'd0;
            sepc_q     <= 32'd0;
            scause_q   <= 32'd0;
            stval_q    <= 32'd0;
            ssip_q     <= 1'b0;
            inhibit_q  <= 32'd0;
        end else begin
            if (csr_we) begin
                case (addr)
                    ADDR_SSTATUS: begin
                        st_sie_q  <= wdata[1];
                        st_spie_q <= wdata[5];
                        st_spp_q  <= wdata[8];
                    end
                    ADDR_SIE:      sie_q      <= wdata & SIE_MASK;
                    ADDR_STVEC:    stvec_q    <= stvec_legal(wdata);
                    ADDR_SSCRATCH: sscratch_q <= wdata;
                    ADDR_SEPC:     sepc_q     <= wdata;
                    ADDR_SCAUSE:   scause_q   <= wdata;
                    ADDR_STVAL:    stval_q    <= wdata;
                    ADDR_SIP:      ssip_q     <= wdata[1];
                    ADDR_SCNTINH:  inhibit_q  <= wdata & INHIBIT_MASK;
                    default: ;
                endcase
            end
            // NOTE: non-blocking updates all read old values; the last assignment in
            // program order wins, which is how trap > trap_ret > CSR op is encoded.
            if (trap_ret) begin
                st_sie_q  <= st_spie_q;
                st_spie_q <= 1'b1;
                st_spp_q  <= 1'b0;
            end
            if (trap) begin
                sepc_q    <= trap_pc & ~32'h3;
                scause_q  <= trap_cause;
                stval_q   <= trap_value;
                st_spie_q <= st_sie_q;
                st_sie_q  <= 1'b0;
                st_spp_q  <= 1'b1;
            end
        end
    end

    // Counters, timer prescaler and input edge detectors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q      <= '0;
            time_q       <= '0;
            instret_q    <= '0;
            presc_q      <= 16'd0;
            inst_prev_q  <= 1'b0;
            timer_prev_q <= 1'b0;
            hpm_prev_q   <= '0;
            // NOTE: the hpm array is a set of flops, not a RAM, so every entry is reset.
            for (int i = 0; i < HPM_W; i++) begin
                hpm_q[i] <= '0;
            end
        end else begin
            inst_prev_q  <= inst_tick;
            timer_prev_q <= timer_tick;
            hpm_prev_q   <= hpm_event;

            if (!inhibit_q[0]) begin
                cycle_q <= cycle_q + CNT_ONE;
            end

            if (inst_tick && !inst_prev_q && !inhibit_q[2]) begin
                instret_q <= instret_q + CNT_ONE;
            end

            // time has no inhibit bit; it advances once every TIME_DIV timer_tick edges
            if (timer_tick && !timer_prev_q) begin
                if (presc_q == PRESC_LAST) begin
                    presc_q <= 16'd0;
                    time_q  <= time_q + CNT_ONE;
                end else begin
                    presc_q <= presc_q + 16'd1;
                end
            end

            for (int i = 0; i < HPM_W; i++) begin
                if (i < int'(NUM_HPM) && hpm_event[i] && !hpm_prev_q[i] && !inhibit_q[3 + i]) begin
                    hpm_q[i] <= hpm_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Interrupt request, registered from current enable and pending state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_req <= 1'b0;
        end else begin
            irq_req <= st_sie_q && |(sip_rd & sie_q);
        end
    end

endmodule
